puf_response_reader: RTL and testbench

- Evaluation side of the enable-gated PUF slice chain: generates challenges, pulses the chain enable, samples the chain outputs, and assembles response words.
- Per response bit: apply a challenge from an internal LFSR, assert enable, wait a fixed settle window, then capture the synchronised chain output.
- Sits between the PUF fabric and the host-side register or UART logic. Returns RESP_BITS-wide words over a valid/ready handshake.

---
 rtl/puf_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/puf_response_reader.sv | 198 +++++++++++++++++++
 tb/tb_puf_response_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared types and helpers for the PUF response reader.
//   puf_state_t  : evaluation FSM states
//   LFSR_TAPS    : tap mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   DEFAULT_SEED : LFSR value used when the seed input is zero
//   lfsr_next()  : one LFSR step (shift left, feedback into bit 0)
// Optional build macro used by the reader: PUF_MAJORITY_EN
// -----------------------------------------------------------------------------
package puf_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      RACE   = 3'd2,
      SAMPLE = 3'd3,
      SHIFT  = 3'd4,
      DONE   = 3'd5
   } puf_state_t;

   // Bit positions 15,13,12,10 correspond to taps 16,14,13,11.
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// 1-bit two-flop synchroniser for the asynchronous PUF chain outputs.
//   clk : system clock
//   rst : asynchronous active-high reset, clears both flops
//   d_i : asynchronous input
//   q_o : synchronised output (two clock cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff_q <= 2'b00;
      end else begin
         ff_q <= {ff_q[0], d_i};
      end
   end

   assign q_o = ff_q[1];

endmodule

// File: rtl/puf_response_reader.sv
// -----------------------------------------------------------------------------
// puf_response_reader
// Evaluation side of an enable-gated PUF slice chain. For each response bit an
// LFSR challenge is applied, the chain enable is pulsed for SETTLE_CYC cycles,
// the synchronised chain output A is sampled and shifted into the response.
// Finished RESP_BITS-wide words are returned over a valid/ready handshake.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, seed[15:0]   : start request (IDLE only) and LFSR seed (0 -> default)
//   chal_sel, chal_bx   : challenge driven to the slice chain
//   chain_en            : enable to all slices (high only in RACE/SAMPLE)
//   chain_a, chain_b    : asynchronous chain outputs
//   resp_data/valid     : response word, MSB = first bit collected
//   resp_ready          : consumer accepts resp_data
//   busy                : high whenever the FSM is not in IDLE
//
// Build macro PUF_MAJORITY_EN: each bit is evaluated three times with the same
// challenge and the bit is the majority of the three A samples.
// -----------------------------------------------------------------------------
module puf_response_reader #(
   parameter int          N_STAGES     = 8,
   parameter int          RESP_BITS    = 16,
   parameter int          SETTLE_CYC   = 8,
   parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [15:0]          seed,
   output logic [N_STAGES-1:0]  chal_sel,
   output logic                 chal_bx,
   output logic                 chain_en,
   input  logic                 chain_a,
   input  logic                 chain_b,
   output logic [RESP_BITS-1:0] resp_data,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 busy
);

   import puf_pkg::*;

   localparam int CNT_W = $clog2(RESP_BITS + 1);
   localparam int RC_W  = $clog2(SETTLE_CYC);

   // ---------------------------------------------------------------- sync
   logic [1:0] chain_raw;
   logic [1:0] chain_sync;
   logic       a_sync;
   logic       unused_b_sync;

   assign chain_raw = {chain_b, chain_a};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         sync_2ff u_sync (
            .clk (clk),
            .rst (rst),
            .d_i (chain_raw[gi]),
            .q_o (chain_sync[gi])
         );
      end
   endgenerate

   assign a_sync        = chain_sync[0];
   // B is synchronised so it can be probed, but the response uses A alone.
   assign unused_b_sync = chain_sync[1];

   // ---------------------------------------------------------------- state
   puf_state_t           state_q;
   logic [15:0]          lfsr_q;
   logic [15:0]          lfsr_d;
   logic [15:0]          seed_eff;
   logic [CNT_W-1:0]     cnt_q;
   logic [RC_W-1:0]      rc_q;
   logic                 bit_q;
   logic [RESP_BITS-1:0] sr_q;
   logic [N_STAGES-1:0]  chal_sel_q;
   logic                 chal_bx_q;
   logic                 chain_en_q;
   logic                 resp_valid_q;
   logic                 busy_q;
`ifdef PUF_MAJORITY_EN
   logic [1:0]           ev_q;    // evaluation index within the current bit
   logic [1:0]           ones_q;  // ones seen in earlier evaluations of this bit
`endif

   assign lfsr_d   = lfsr_next(lfsr_q);
   assign seed_eff = (seed == 16'd0) ? DEFAULT_SEED : seed;

   // Challenge outputs are registered copies of the LFSR so that reset can
   // force them to zero while the LFSR itself resets to DEFAULT_SEED.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         lfsr_q       <= DEFAULT_SEED;
         cnt_q        <= '0;
         rc_q         <= '0;
         bit_q        <= 1'b0;
         sr_q         <= '0;
         chal_sel_q   <= '0;
         chal_bx_q    <= 1'b0;
         chain_en_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef PUF_MAJORITY_EN
         ev_q         <= 2'd0;
         ones_q       <= 2'd0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  lfsr_q     <= seed_eff;
                  chal_sel_q <= seed_eff[N_STAGES-1:0];
                  chal_bx_q  <= seed_eff[15];
                  cnt_q      <= '0;
                  sr_q       <= '0;
                  busy_q     <= 1'b1;
`ifdef PUF_MAJORITY_EN
                  ev_q       <= 2'd0;
                  ones_q     <= 2'd0;
`endif
                  state_q    <= ARM;
               end
            end
            ARM: begin
               rc_q       <= '0;
               chain_en_q <= 1'b1;
               state_q    <= RACE;
            end
            RACE: begin
               if (rc_q == RC_W'(SETTLE_CYC - 1)) begin
                  state_q <= SAMPLE;
               end else begin
                  rc_q <= rc_q + 1'b1;
               end
            end
            SAMPLE: begin
               chain_en_q <= 1'b0;
`ifdef PUF_MAJORITY_EN
               if (ev_q == 2'd2) begin
                  // Majority of three: two earlier ones, or one plus this sample.
                  bit_q   <= (ones_q == 2'd2) || ((ones_q == 2'd1) && a_sync);
                  state_q <= SHIFT;
               end else begin
                  ones_q  <= ones_q + {1'b0, a_sync};
                  ev_q    <= ev_q + 2'd1;
                  state_q <= ARM;
               end
`else
               bit_q   <= a_sync;
               state_q <= SHIFT;
`endif
            end
            SHIFT: begin
               sr_q       <= RESP_BITS'({sr_q, bit_q});
               lfsr_q     <= lfsr_d;
               chal_sel_q <= lfsr_d[N_STAGES-1:0];
               chal_bx_q  <= lfsr_d[15];
               cnt_q      <= cnt_q + 1'b1;
`ifdef PUF_MAJORITY_EN
               ev_q       <= 2'd0;
               ones_q     <= 2'd0;
`endif
               if (cnt_q == CNT_W'(RESP_BITS - 1)) begin
                  resp_valid_q <= 1'b1;
                  state_q      <= DONE;
               end else begin
                  state_q <= ARM;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               chain_en_q   <= 1'b0;
               resp_valid_q <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign chal_sel   = chal_sel_q;
   assign chal_bx    = chal_bx_q;
   assign chain_en   = chain_en_q;
   assign resp_data  = sr_q;
   assign resp_valid = resp_valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_puf_response_reader.sv
// -----------------------------------------------------------------------------
// tb_puf_response_reader
// Randomised bench for puf_response_reader. A behavioural chain model drives
// chain_a (constant, challenge parity, or a 1,0,1 toggle per evaluation) and
// a reference model predicts the challenge sequence, response word, start to
// valid latency and enable pulse widths. Honours PUF_MAJORITY_EN.
// -----------------------------------------------------------------------------
module tb_puf_response_reader;

   localparam int NS = 8;
   localparam int RB = 16;
   localparam int SC = 8;
`ifdef PUF_MAJORITY_EN
   localparam int NEVAL   = 3;
   localparam int BIT_LAT = 3 * (SC + 2) + 1;
`else
   localparam int NEVAL   = 1;
   localparam int BIT_LAT = SC + 3;
`endif
   localparam int LAT = RB * BIT_LAT + 1;

   logic          clk;
   logic          rst;
   logic          start;
   logic [15:0]   seed;
   logic [NS-1:0] chal_sel;
   logic          chal_bx;
   logic          chain_en;
   logic          chain_a;
   logic          chain_b;
   logic [RB-1:0] resp_data;
   logic          resp_valid;
   logic          resp_ready;
   logic          busy;

   int   total;
   int   bad;
   int   chain_mode;
   logic const_val;
   int   eval_idx;

   puf_response_reader #(
      .N_STAGES     (NS),
      .RESP_BITS    (RB),
      .SETTLE_CYC   (SC),
      .DEFAULT_SEED (16'hACE1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .seed       (seed),
      .chal_sel   (chal_sel),
      .chal_bx    (chal_bx),
      .chain_en   (chain_en),
      .chain_a    (chain_a),
      .chain_b    (chain_b),
      .resp_data  (resp_data),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Chain model: B always disagrees with A, which must not matter.
   always_comb begin
      case (chain_mode)
         0:       chain_a = const_val;
         1:       chain_a = (^chal_sel) ^ chal_bx;
         default: chain_a = ((eval_idx % 3) != 1);
      endcase
      chain_b = ~chain_a;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // LFSR step from the tap list 16,14,13,11 using plain arithmetic.
   function automatic logic [15:0] ref_step(input logic [15:0] v);
      logic [15:0] fb;
      fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 16'h0001;
      return (v << 1) | fb;
   endfunction

   task automatic run_one(input logic [15:0] sd, input int mode, input int hold,
                          input bit ready_early, input bit poke);
      logic [15:0]   l;
      logic [RB-1:0] exp_data;
      logic [8:0]    exp_chal [RB];
      int            ones;
      bit            b;
      int            cyc;
      int            pulses;
      int            width;
      int            bad_w;
      int            stable_bad;
      bit            prev_en;

      // Reference model.
      l        = (sd == 16'd0) ? 16'hACE1 : sd;
      exp_data = '0;
      for (int i = 0; i < RB; i++) begin
         exp_chal[i] = {l[15], l[7:0]};
         if (mode == 0) begin
            b = const_val;
         end else if (mode == 1) begin
            b = (^l[7:0]) ^ l[15];
         end else begin
            ones = 0;
            for (int k = 0; k < NEVAL; k++) ones += (((i * NEVAL + k) % 3) != 1) ? 1 : 0;
            b = (2 * ones > NEVAL);
         end
         exp_data = {exp_data[RB-2:0], b};
         l = ref_step(l);
      end

      @(negedge clk);
      chain_mode = mode;
      eval_idx   = 0;
      seed       = sd;
      start      = 1'b1;
      resp_ready = ready_early;
      cyc = 0; pulses = 0; width = 0; bad_w = 0; prev_en = 1'b0;

      while (!resp_valid && cyc < LAT + 50) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (chain_en) begin
            if (!prev_en) begin
               if (pulses / NEVAL < RB)
                  check("chal", {chal_bx, chal_sel}, exp_chal[pulses / NEVAL]);
               else
                  check("extra_pulse", pulses, RB * NEVAL - 1);
               eval_idx = pulses;
               pulses++;
            end
            width++;
         end else if (prev_en) begin
            if (width != SC + 1) bad_w++;
            width = 0;
         end
         prev_en = chain_en;
      end
      start = 1'b0;

      check("latency", cyc, LAT);
      check("resp_data", resp_data, exp_data);
      check("pulses", pulses, RB * NEVAL);
      check("en_width", bad_w, 0);
      $display("txn seed=%h mode=%0d data=%h lat=%0d", sd, mode, resp_data, cyc);

      if (ready_early) begin
         @(posedge clk);
         #1;
         check("early_valid", resp_valid, 1'b0);
         check("early_busy", busy, 1'b0);
         @(negedge clk);
         resp_ready = 1'b0;
      end else begin
         stable_bad = 0;
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            start = poke && ((k % 4) == 1);
            @(posedge clk);
            #1;
            if (!resp_valid || resp_data !== exp_data || chain_en) stable_bad++;
         end
         @(negedge clk);
         start      = 1'b0;
         check("hold", stable_bad, 0);
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         check("hs_valid", resp_valid, 1'b0);
         check("hs_busy", busy, 1'b0);
         @(negedge clk);
         resp_ready = 1'b0;
      end
      @(posedge clk);
      #1;
      check("no_restart", busy, 1'b0);
   endtask

   task automatic reset_mid_race();
      int n;
      @(negedge clk);
      chain_mode = 1;
      seed       = 16'h4321;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      while (!chain_en && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("race_seen", chain_en, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_en", chain_en, 1'b0);
      check("rst_sel", {chal_bx, chal_sel}, 9'd0);
      check("rst_valid", resp_valid, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_data", resp_data, '0);
      $display("txn reset mid-race busy=%0d chain_en=%0d", busy, chain_en);
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; start = 1'b0; seed = 16'd0; resp_ready = 1'b0;
      chain_mode = 0; const_val = 1'b0; eval_idx = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outs", {chal_bx, chal_sel, chain_en, resp_valid, busy}, '0);
      check("rst_resp", resp_data, '0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_busy", busy, 1'b0);

      run_one(16'h0000, 1, 3, 1'b0, 1'b0);   // default seed substitution
      run_one(16'h1234, 1, 0, 1'b1, 1'b0);   // parity chain, ready already high
      const_val = 1'b1;
      run_one(16'h5A5A, 0, 20, 1'b0, 1'b1);  // constant 1, backpressure + start pokes
      run_one(16'hBEEF, 2, 2, 1'b0, 1'b0);   // 1,0,1 toggle across evaluations
      reset_mid_race();
      for (int r = 0; r < 5; r++) begin
         const_val = 1'($urandom_range(0, 1));
         run_one(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 6),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
